atomic_alu_scheduler: RTL



---
 rtl/atomic_alu_pkg.sv | 42 ++++
 rtl/atomic_alu_scheduler_rr_arbiter.sv | 31 +++
 rtl/atomic_alu_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/atomic_alu_pkg.sv
// Shared types and command-field helpers for the atomic ALU scheduler.
// A command is {op[2:0], addr1[2:0], addr2[2:0], addr3[2:0]}.
package atomic_alu_pkg;

  localparam int CMD_W   = 12;
  localparam int FIELD_W = 3;
  localparam int OP_LSB  = 9;
  localparam int A1_LSB  = 6;
  localparam int A2_LSB  = 3;
  localparam int A3_LSB  = 0;

  typedef logic [2:0] op_t;

  localparam op_t CMP_OP = 3'b001;
  localparam op_t CAS_OP = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WB       = 3'd3,
    ST_CAS_WR   = 3'd4,
    ST_CAS_FAIL = 3'd5
  } state_t;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } flags_t;

  function automatic op_t cmd_op(input logic [CMD_W-1:0] cmd);
    return cmd[OP_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] cmd_field(input logic [CMD_W-1:0] cmd,
                                                   input int lsb);
    return cmd[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/atomic_alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i,
// wrapping modulo NREQ. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_id_o,
  output logic            any_o
);

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    // Scan from the farthest offset down so the nearest valid index wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_i) + k) % NREQ;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_id_o   = IDW'(idx);
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atomic_alu_scheduler.sv
// Shares one ALU and the register file among NREQ requesters, one command in
// flight at a time; compare-and-swap runs as an uninterruptible sequence.
module atomic_alu_scheduler
  import atomic_alu_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [3:0]            rsp_flags,
  output logic                  busy,
  output logic [REG_AW-1:0]     rf_raddr_a,
  output logic [REG_AW-1:0]     rf_raddr_b,
  input  logic [DATA_W-1:0]     rf_rdata_a,
  input  logic [DATA_W-1:0]     rf_rdata_b,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [2:0]            alu_op_code,
  output logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     data_b,
  input  logic [DATA_W-1:0]     y,
  input  logic                  O,
  input  logic                  C,
  input  logic                  Z,
  input  logic                  N
);

  state_t              state_q,  state_d;
  logic [IDW-1:0]      rr_q,     rr_d;
  logic [CMD_W-1:0]    cmd_q,    cmd_d;
  logic [IDW-1:0]      id_q,     id_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  op_t                 alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   result_q, result_d;
  flags_t              flags_q,  flags_d;

  logic [NREQ-1:0]     arb_grant;
  logic [IDW-1:0]      arb_id;
  logic                arb_any;
  logic [CMD_W-1:0]    cmd_sel;
  logic [REG_AW-1:0]   a1, a2, a3;
  logic                is_cas;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i      (req_valid),
    .ptr_i      (rr_q),
    .grant_o    (arb_grant),
    .grant_id_o (arb_id),
    .any_o      (arb_any)
  );

  assign cmd_sel = req_cmd[int'(arb_id)*CMD_W +: CMD_W];
  assign a1      = REG_AW'(cmd_field(cmd_q, A1_LSB));
  assign a2      = REG_AW'(cmd_field(cmd_q, A2_LSB));
  assign a3      = REG_AW'(cmd_field(cmd_q, A3_LSB));
  assign is_cas  = (cmd_op(cmd_q) == CAS_OP);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cmd_d      = cmd_q;
    id_d       = id_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    alu_op_d   = alu_op_q;
    result_d   = result_q;
    flags_d    = flags_q;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_flags  = '0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          // Masked while reset is held so no grant is advertised that cannot be taken.
          req_ready = rst_n ? arb_grant : '0;
          cmd_d     = cmd_sel;
          id_d      = arb_id;
          rr_d      = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + IDW'(1);
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        rf_raddr_a = a1;
        rf_raddr_b = a2;
        data_a_d   = rf_rdata_a;
        data_b_d   = rf_rdata_b;
        alu_op_d   = is_cas ? CMP_OP : cmd_op(cmd_q);
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = y;
        flags_d  = {O, C, Z, N};
        if (!is_cas)  state_d = ST_WB;
        else if (Z)   state_d = ST_CAS_WR;
        else          state_d = ST_CAS_FAIL;
      end
      ST_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = a3;
        rf_wdata  = result_q;
        rsp_valid = 1'b1;
        rsp_data  = result_q;
        rsp_flags = flags_q;
        state_d   = ST_IDLE;
      end
      ST_CAS_WR: begin
        // Port A is free after the compare, so it fetches the swap value.
        rf_raddr_a = a3;
        rf_we      = 1'b1;
        rf_waddr   = a1;
        rf_wdata   = rf_rdata_a;
        rsp_valid  = 1'b1;
        rsp_data   = DATA_W'(1);
        rsp_flags  = flags_q;
        state_d    = ST_IDLE;
      end
      ST_CAS_FAIL: begin
        rsp_valid = 1'b1;
        rsp_flags = flags_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      cmd_q    <= '0;
      id_q     <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cmd_q    <= cmd_d;
      id_q     <= id_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign alu_op_code = alu_op_q;
  assign data_a      = data_a_q;
  assign data_b      = data_b_q;
  assign rsp_id      = id_q;

endmodule
